// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller with a single-block refill FSM.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_ctrl #(
    parameter int NUM_SETS = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         READ,
    input  logic [31:0]  ADDRESS,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic [27:0]  MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]  HIT_COUNT,
    output logic [31:0]  MISS_COUNT
`endif
);
    localparam int IDX   = $clog2(NUM_SETS);
    localparam int TAG_W = 28 - IDX;

    typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_t;

    state_t               state_q, state_d;
    logic [127:0]         data_q [NUM_SETS];
    logic [TAG_W-1:0]     tag_q  [NUM_SETS];
    logic [NUM_SETS-1:0]  valid_q;
    logic [27:0]          mem_addr_q;

    logic [IDX-1:0]       idx;
    logic [TAG_W-1:0]     tag;
    logic [1:0]           word;
    logic [127:0]         line;
    logic [31:0]          words [4];
    logic                 hit;
    logic                 miss_start;
    logic                 fill_done;
    logic [IDX-1:0]       fill_idx;
    logic [TAG_W-1:0]     fill_tag;
    logic                 unused_addr;

    assign idx         = ADDRESS[4 +: IDX];
    assign tag         = ADDRESS[31 -: TAG_W];
    assign word        = ADDRESS[3:2];
    assign unused_addr = ^ADDRESS[1:0];
    assign line        = data_q[idx];
    assign hit         = READ & valid_q[idx] & (tag_q[idx] == tag);

    // The refill always targets the latched block address, not the live CPU address.
    assign fill_idx    = mem_addr_q[IDX-1:0];
    assign fill_tag    = mem_addr_q[27 -: TAG_W];
    assign miss_start  = (state_q == IDLE) & READ & ~hit;
    assign fill_done   = (state_q == FETCH) & ~MEM_BUSYWAIT;
    assign MEM_ADDRESS = mem_addr_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word
            assign words[gi] = line[32*gi +: 32];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        BUSYWAIT    = 1'b0;
        MEM_READ    = 1'b0;
        INSTRUCTION = words[word];
        unique case (state_q)
            IDLE: begin
                BUSYWAIT = READ & ~hit;
                if (miss_start) state_d = FETCH;
            end
            FETCH: begin
                BUSYWAIT = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) state_d = UPDATE;
            end
            UPDATE: begin
                BUSYWAIT = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) mem_addr_q <= ADDRESS[31:4];
            if (fill_done)  valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; a reset during a fill suppresses the write.
    always_ff @(posedge CLK) begin
        if (!RESET && fill_done) begin
            data_q[fill_idx] <= MEM_READDATA;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if ((state_q == IDLE) && hit && (hit_cnt_q != 32'hFFFF_FFFF))
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF))
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: directed scenarios plus randomized fetches against a
// block-level cache model; a monitor pops expectations whenever a fetch completes.
module tb_icache_ctrl;
    localparam int NS = 8;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         READ;
    logic [31:0]  ADDRESS;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  HIT_COUNT;
    logic [31:0]  MISS_COUNT;
`endif

    icache_ctrl #(.NUM_SETS(NS)) dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .ADDRESS(ADDRESS),
        .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef ICACHE_PERF_CNT_EN
        , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        int          stall;
        bit          miss;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    int          mem_lat = 0;
    bit          mon_en = 0;
    bit          ref_valid [NS];
    logic [27:0] ref_blk   [NS];
    int          exp_hits = 0;
    int          exp_misses = 0;

    function automatic logic [31:0] mem_word(logic [27:0] blk, int k);
        logic [127:0] cold = 128'h00C58633_00B50533_00200593_00100513;
        if (blk == 28'd0) return cold[32*k +: 32];
        return (32'(blk) * 32'h9E37_79B1) ^ (32'(k) * 32'h0123_4567) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [127:0] mem_block(logic [27:0] blk);
        logic [127:0] b;
        for (int k = 0; k < 4; k++) b[32*k +: 32] = mem_word(blk, k);
        return b;
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Instruction memory: MEM_BUSYWAIT stays high for mem_lat FETCH cycles, then drops.
    initial begin
        int rem;
        bit in_f;
        rem = 0;
        in_f = 0;
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = '0;
        forever begin
            @(negedge CLK);
            if (MEM_READ) begin
                if (!in_f) begin
                    in_f = 1;
                    rem  = mem_lat;
                end
                if (rem > 0) begin
                    MEM_BUSYWAIT = 1'b1;
                    MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
                    rem--;
                end else begin
                    MEM_BUSYWAIT = 1'b0;
                    MEM_READDATA = mem_block(MEM_ADDRESS);
                end
            end else begin
                in_f = 0;
                MEM_BUSYWAIT = 1'b1;
            end
        end
    end

    // Monitor: counts stall cycles and pops the scoreboard when a fetch is delivered.
    initial begin
        int          stall;
        logic [27:0] seen_ma;
        bit          seen;
        exp_t        e;
        stall = 0;
        seen = 0;
        seen_ma = 'x;
        forever begin
            @(negedge CLK);
            if (RESET || !mon_en) begin
                stall = 0;
                seen = 0;
                seen_ma = 'x;
            end else if (READ) begin
                if (BUSYWAIT) begin
                    stall++;
                    if (MEM_READ && !seen) begin
                        seen = 1;
                        seen_ma = MEM_ADDRESS;
                    end
                end else begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty actual=delivery addr %h required=no delivery", ADDRESS);
                    end else begin
                        e = sb_q.pop_front();
                        check("word", INSTRUCTION, e.word);
                        check("stall", stall, e.stall);
                        if (e.miss) check("mem_addr", seen_ma, e.addr[31:4]);
                        $display("txn addr=%h word=%h stall=%0d miss=%0d", e.addr, INSTRUCTION, stall, e.miss);
                    end
                    stall = 0;
                    seen = 0;
                    seen_ma = 'x;
                end
            end else begin
                check("idle_busywait", BUSYWAIT, 0);
                check("idle_mem_read", MEM_READ, 0);
            end
        end
    end

    task automatic txn(logic [31:0] addr, int lat);
        exp_t        e;
        int          n;
        int          idx;
        logic [27:0] blk;
        bit          hit;
        blk = addr[31:4];
        idx = int'(blk % NS);
        hit = ref_valid[idx] && (ref_blk[idx] == blk);
        e.addr  = addr;
        e.word  = mem_word(blk, int'(addr[3:2]));
        e.miss  = !hit;
        e.stall = hit ? 0 : lat + 3;
        if (!hit) begin
            ref_valid[idx] = 1;
            ref_blk[idx]   = blk;
            exp_misses++;
        end
        exp_hits++;
        sb_q.push_back(e);
        mem_lat = lat;
        READ    = 1'b1;
        ADDRESS = addr;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (BUSYWAIT && n < 200);
        if (BUSYWAIT) begin
            checks++;
            errors++;
            $display("FAIL timeout addr=%h actual=busy required=delivered", addr);
            sb_q.delete();
        end
        @(posedge CLK); #1;
    endtask

    task automatic idle(int n);
        READ = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NS; i++) ref_valid[i] = 0;
        exp_hits = 0;
        exp_misses = 0;
    endtask

    task automatic do_reset();
        mon_en = 0;
        RESET  = 1'b1;
        READ   = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        clear_model();
        @(negedge CLK);
        check("rst_mem_read", MEM_READ, 0);
        check("rst_mem_addr", MEM_ADDRESS, 0);
        check("rst_busywait", BUSYWAIT, 0);
`ifdef ICACHE_PERF_CNT_EN
        check("rst_hit_count", HIT_COUNT, 0);
        check("rst_miss_count", MISS_COUNT, 0);
`endif
        @(posedge CLK); #1;
        mon_en = 1;
    endtask

    task automatic check_perf();
`ifdef ICACHE_PERF_CNT_EN
        @(negedge CLK);
        check("hit_count", HIT_COUNT, exp_hits);
        check("miss_count", MISS_COUNT, exp_misses);
        @(posedge CLK); #1;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] blk;
        logic [1:0]  w;
        RESET   = 1'b1;
        READ    = 1'b0;
        ADDRESS = '0;
        repeat (2) @(posedge CLK);
        #1;
        do_reset();

        // Cold miss then three consecutive hits in the same line.
        txn(32'h0000_0000, 15);
        txn(32'h0000_0004, 0);
        txn(32'h0000_0008, 0);
        txn(32'h0000_000C, 0);
        idle(1);
        check_perf();
        do_reset();

        // Conflict on index 0.
        txn(32'h0000_0000, 2);
        txn(32'h0000_0080, 4);
        txn(32'h0000_0000, 1);
        idle(2);

        // Reset in the middle of a fill.
        mon_en  = 0;
        mem_lat = 20;
        READ    = 1'b1;
        ADDRESS = 32'h0000_0100;
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        check("midfill_mem_read", MEM_READ, 1);
        RESET = 1'b1;
        READ  = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        clear_model();
        @(negedge CLK);
        check("post_rst_mem_read", MEM_READ, 0);
        check("post_rst_busywait", BUSYWAIT, 0);
        check("post_rst_mem_addr", MEM_ADDRESS, 0);
        @(posedge CLK); #1;
        mon_en = 1;
        txn(32'h0000_0004, 2);

        // Idle with an uncached address, then a zero-latency miss.
        ADDRESS = 32'h0001_2340;
        idle(10);
        txn(32'h0000_5000, 0);
        idle(1);
        check_perf();

        for (int t = 0; t < 300; t++) begin
            blk = 28'(($urandom_range(0, 3) << 20) | $urandom_range(0, 23));
            w   = 2'($urandom_range(0, 3));
            txn({blk, w, 2'($urandom_range(0, 3))}, $urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(2);
        check_perf();
        check("sb_drain", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped, read-only instruction cache controller between the CPU fetch stage and the 128-bit block instruction memory.
- Holds tag, valid and 128-bit data arrays, and returns the 32-bit word for a hit.
- On a miss it stalls the CPU and sequences one block read from instruction memory (MEM_READ/MEM_BUSYWAIT handshake), then refills the line.

Parameters:
- NUM_SETS, 8, number of cache lines; power of two, 2..256; IDX = log2(NUM_SETS).

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RESET  input  1  synchronous, active-high reset
- READ  input  1  fetch request from CPU
- ADDRESS  input  32  fetch byte address; bits [1:0] ignored
- INSTRUCTION  output  32  fetched word; meaningful only when READ=1 and BUSYWAIT=0
- BUSYWAIT  output  1  CPU stall
- MEM_READ  output  1  block read request to instruction memory
- MEM_ADDRESS  output  28  block address (byte address >> 4)
- MEM_READDATA  input  128  block data; byte 0 in bits [7:0]
- MEM_BUSYWAIT  input  1  memory busy; low = MEM_READDATA valid

Behaviour:
- Address split: word = ADDRESS[3:2]; index = ADDRESS[4+IDX-1:4]; tag = ADDRESS[31:4+IDX] (25 bits at default).
- Word select: word k = line[32k+31:32k].
- hit = READ & valid[index] & (tag_array[index] == tag); combinational.
- State machine: IDLE, FETCH, UPDATE; state register changes only on the rising edge.
  - IDLE: BUSYWAIT = READ & ~hit, combinational, same cycle. INSTRUCTION = selected word of data[index] (combinational). On a miss at the edge: go to FETCH and latch MEM_ADDRESS <= ADDRESS[31:4].
  - FETCH: MEM_READ=1, BUSYWAIT=1. Stay while MEM_BUSYWAIT=1. At the first edge with MEM_BUSYWAIT=0: write data[fill_idx] <= MEM_READDATA, tag and valid <= 1, then go to UPDATE.
  - UPDATE: MEM_READ=0, BUSYWAIT=1. Next edge goes unconditionally to IDLE, where the hit is re-evaluated.
- Miss latency: BUSYWAIT high for 1 (IDLE) + N (memory busy cycles incl. completion) + 1 (UPDATE) cycles. The word is delivered in the first IDLE cycle after UPDATE.
- MEM_READ is decoded from the state only: high exactly in FETCH, glitch-free.
- MEM_ADDRESS is held from latch until the next miss. The fill always targets the latched address. If the CPU changes ADDRESS during a stall, the return to IDLE re-checks the new address and may miss again.
- READ=0 in IDLE: BUSYWAIT=0, no state change, no memory traffic. READ is ignored in FETCH and UPDATE; a started fill always completes.
- MEM_BUSYWAIT=0 on the first FETCH cycle is legal: FETCH lasts one cycle.
- RESET=1 at an edge:
  - state <= IDLE; all valid bits <= 0; MEM_ADDRESS <= 0.
  - Tag and data arrays are not cleared.
  - A reset mid-FETCH abandons the fill: MEM_READ is low from the following cycle and no line is written.
- Outputs after reset: MEM_READ=0, MEM_ADDRESS=0. BUSYWAIT = READ (everything misses).
- Reset priority: RESET overrides any simultaneous fill completion.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs HIT_COUNT[31:0] and MISS_COUNT[31:0], both cleared by RESET.
  - HIT_COUNT increments on each edge in IDLE with READ & hit.
  - MISS_COUNT increments on each IDLE->FETCH transition.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss: RESET 1 cycle, then READ=1, ADDRESS=32'h0000_0000.
  - BUSYWAIT=1 same cycle.
  - Next edge: MEM_READ=1, MEM_ADDRESS=28'h0000000.
  - Memory model holds MEM_BUSYWAIT=1 for 15 cycles, then drops it with MEM_READDATA=128'h00C58633_00B50533_00200593_00100513.
  - One cycle later MEM_READ=0. Next cycle BUSYWAIT=0 and INSTRUCTION=32'h00100513.
- Hits after the cold-miss fill: ADDRESS=0x4, 0x8, 0xC on consecutive cycles.
  - BUSYWAIT=0 throughout, MEM_READ stays 0.
  - INSTRUCTION = 32'h00200593, 32'h00B50533, 32'h00C58633.
- Conflict (NUM_SETS=8):
  - ADDRESS=32'h0000_0080 (index 0, tag 1) misses; MEM_ADDRESS=28'h0000008. Fill with a distinct block; word 0 is returned.
  - ADDRESS=32'h0000_0000 then misses again.
- Reset mid-fill: assert RESET for one cycle during FETCH while MEM_BUSYWAIT=1.
  - MEM_READ=0 the following cycle; state is IDLE.
  - A previously filled ADDRESS=32'h0000_0004 now misses.
- Idle / zero-latency memory:
  - READ=0 with an uncached address: BUSYWAIT=0, MEM_READ=0 for 10 cycles.
  - Miss with MEM_BUSYWAIT tied 0: BUSYWAIT high exactly 3 cycles.
- With ICACHE_PERF_CNT_EN: run the cold-miss and hit scenarios above (cold miss, then 0x4/0x8/0xC hits).
  - Expect MISS_COUNT=1, HIT_COUNT=4 (post-fill hit at 0x0 plus 3).
  - After RESET both read 0.
